var_states_xfer: RTL and testbench

- Bulk mover between the global variable-state memory and one SAT engine's var_state array.
- LOAD reads NUM_VARS consecutive state words (value[2:0], lvl[WIDTH_LVL-1:0]) and writes each into its var_state instance through a one-hot write strobe.
- STORE snapshots every var_state output in one cycle, then writes the words back to memory sequentially.
- Sits between the bin manager (start/done) and the state list; the var_state instances are on the receiving end of this block.

---
 rtl/var_states_xfer_if.sv | 23 ++
 rtl/var_states_xfer.sv | 159 +++++++++++++++
 tb/tb_var_states_xfer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/var_states_xfer_if.sv
// Memory-side port bundle for var_states_xfer: one read port (data one cycle
// after the strobe) and one write port, both driven by the mover.
interface var_states_xfer_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 19
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;

  modport master (
    output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    input  mem_rd_data
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/var_states_xfer.sv
// Bulk LOAD/STORE of NUM_VARS var_state words between memory and one engine; LOAD done
// NUM_VARS+2 cycles after start, STORE NUM_VARS+1; no backpressure, memory always ready.
module var_states_xfer #(
  parameter int NUM_VARS         = 8,
  parameter int WIDTH_LVL        = 16,
  parameter int WIDTH_VAR_STATES = 19,
  parameter int ADDR_W           = 10
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_load_i,
  input  logic                                 start_store_i,
  input  logic [ADDR_W-1:0]                    base_vid_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic [WIDTH_LVL-1:0]                 load_max_lvl_o,
  var_states_xfer_if.master                    mem_if,
  output logic [NUM_VARS-1:0]                  wr_states_o,
  output logic [WIDTH_VAR_STATES-1:0]          var_states_o,
  input  logic [NUM_VARS*WIDTH_VAR_STATES-1:0] var_states_i
);
  localparam int W     = WIDTH_VAR_STATES;
  localparam int CNT_W = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_VARS - 1);

  typedef enum logic [2:0] {IDLE, LOAD_RD, LOAD_DRAIN, STORE_WR, DONE} state_t;

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         base_q, base_d;
  logic [CNT_W-1:0]          k_q, k_d, k_nxt;
  logic [NUM_VARS*W-1:0]     snap_q, snap_d;
  logic                      rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]         rd_addr_q, rd_addr_d;
  logic                      wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]         wr_addr_q, wr_addr_d;
  logic [W-1:0]              wr_data_q, wr_data_d;
  logic                      pv_vld_q, pv_vld_d;
  logic [CNT_W-1:0]          pv_k_q, pv_k_d;
  logic [WIDTH_LVL-1:0]      max_q, max_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [WIDTH_LVL-1:0]      rd_lvl;
  logic                      rd_assigned;

  assign rd_lvl      = mem_if.mem_rd_data[WIDTH_LVL-1:0];
  assign rd_assigned = |mem_if.mem_rd_data[W-1:W-2];

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    k_d       = k_q;
    k_nxt     = k_q + CNT_W'(1);
    snap_d    = snap_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    pv_vld_d  = rd_en_q;
    pv_k_d    = k_q;
    max_d     = max_q;

    // Running max only over assigned variables (value[2:1] != 0).
    if (pv_vld_q && rd_assigned && (rd_lvl > max_q)) max_d = rd_lvl;

    case (state_q)
      IDLE: begin
        if (start_load_i) begin
          state_d   = LOAD_RD;
          base_d    = base_vid_i;
          k_d       = '0;
          max_d     = '0;
          rd_en_d   = 1'b1;
          rd_addr_d = base_vid_i;
        end else if (start_store_i) begin
          state_d   = STORE_WR;
          base_d    = base_vid_i;
          k_d       = '0;
          snap_d    = var_states_i;
          wr_en_d   = 1'b1;
          wr_addr_d = base_vid_i;
          wr_data_d = var_states_i[W-1:0];
        end
      end
      LOAD_RD: begin
        if (k_q == LAST) begin
          state_d = LOAD_DRAIN;
        end else begin
          k_d       = k_nxt;
          rd_en_d   = 1'b1;
          rd_addr_d = base_q + ADDR_W'(k_nxt);
        end
      end
      LOAD_DRAIN: state_d = DONE;
      STORE_WR: begin
        if (k_q == LAST) begin
          state_d = DONE;
        end else begin
          k_d       = k_nxt;
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + ADDR_W'(k_nxt);
          wr_data_d = snap_q[int'(k_nxt)*W +: W];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == LOAD_RD) || (state_d == LOAD_DRAIN) || (state_d == STORE_WR);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      k_q       <= '0;
      snap_q    <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pv_vld_q  <= 1'b0;
      pv_k_q    <= '0;
      max_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      k_q       <= k_d;
      snap_q    <= snap_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pv_vld_q  <= pv_vld_d;
      pv_k_q    <= pv_k_d;
      max_q     <= max_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign mem_if.mem_rd_en   = rd_en_q;
  assign mem_if.mem_rd_addr = rd_addr_q;
  assign mem_if.mem_wr_en   = wr_en_q;
  assign mem_if.mem_wr_addr = wr_addr_q;
  assign mem_if.mem_wr_data = wr_data_q;

  // Read data is passed straight through in its valid cycle.
  assign wr_states_o    = pv_vld_q ? (NUM_VARS'(1) << pv_k_q) : '0;
  assign var_states_o   = pv_vld_q ? mem_if.mem_rd_data : '0;
  assign load_max_lvl_o = max_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
endmodule

// File: tb/tb_var_states_xfer.sv
// Bench for var_states_xfer: table of LOAD/STORE operations checked through a
// read/strobe/write scoreboard, plus store-during-load and mid-load reset sequences.
module tb_var_states_xfer;
  localparam int NV = 8;
  localparam int WL = 16;
  localparam int W  = 19;
  localparam int AW = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start_load_i = 1'b0;
  logic            start_store_i = 1'b0;
  logic [AW-1:0]   base_vid_i = '0;
  logic            busy_o, done_o;
  logic [WL-1:0]   load_max_lvl_o;
  logic [NV-1:0]   wr_states_o;
  logic [W-1:0]    var_states_o;
  logic [NV*W-1:0] var_states_i = '0;

  var_states_xfer_if #(.ADDR_W(AW), .DATA_W(W)) mif ();

  var_states_xfer #(
    .NUM_VARS(NV), .WIDTH_LVL(WL), .WIDTH_VAR_STATES(W), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .start_load_i(start_load_i), .start_store_i(start_store_i),
    .base_vid_i(base_vid_i), .busy_o(busy_o), .done_o(done_o),
    .load_max_lvl_o(load_max_lvl_o), .mem_if(mif),
    .wr_states_o(wr_states_o), .var_states_o(var_states_o),
    .var_states_i(var_states_i)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [1024];
  always @(posedge clk) if (mif.mem_rd_en) mif.mem_rd_data <= mem[mif.mem_rd_addr];

  typedef struct {
    int            op;        // 0 load, 1 store, 2 both requests
    logic [AW-1:0] base;
    logic [W-1:0]  words [NV];
    logic [WL-1:0] exp_max;
    int            exp_lat;
  } vec_t;

  vec_t vecs [6];
  logic [63:0] exp_rd_q [$];
  logic [63:0] exp_stb_q [$];
  logic [63:0] exp_wr_q [$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mif.mem_rd_en !== 1'b0) begin
      if (exp_rd_q.size() > 0) chk("rd_addr", 64'(mif.mem_rd_addr), exp_rd_q.pop_front());
      else chk("unexpected_read", 64'(mif.mem_rd_addr), 64'hFFFF_FFFF);
    end
    if (wr_states_o !== '0) begin
      if (exp_stb_q.size() > 0) chk("strobe", 64'({wr_states_o, var_states_o}), exp_stb_q.pop_front());
      else chk("unexpected_strobe", 64'({wr_states_o, var_states_o}), 64'hFFFF_FFFF);
    end
    if (mif.mem_wr_en !== 1'b0) begin
      if (exp_wr_q.size() > 0) chk("wr", 64'({mif.mem_wr_addr, mif.mem_wr_data}), exp_wr_q.pop_front());
      else chk("unexpected_write", 64'({mif.mem_wr_addr, mif.mem_wr_data}), 64'hFFFF_FFFF);
    end
    if (done_o === 1'b1) done_cnt++;
  end

  task automatic run_vec(input int vi, input int pulse_at, input int rst_at);
    vec_t v;
    int n;
    bit seen;
    logic busy_at_done;
    logic [AW-1:0] a;
    logic [NV-1:0] oh;
    v = vecs[vi];
    for (int k = 0; k < NV; k++) begin
      a  = v.base + AW'(k);
      oh = NV'(1) << k;
      if (v.op != 1) begin
        mem[a] = v.words[k];
        exp_rd_q.push_back(64'(a));
        exp_stb_q.push_back(64'({oh, v.words[k]}));
      end else begin
        exp_wr_q.push_back(64'({a, v.words[k]}));
      end
      var_states_i[k*W +: W] = v.words[k];
    end
    done_cnt = 0;
    @(negedge clk);
    start_load_i  = (v.op != 1);
    start_store_i = (v.op != 0);
    base_vid_i    = v.base;
    n = 0;
    seen = 1'b0;
    busy_at_done = 1'b1;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start_load_i  = 1'b0;
      start_store_i = 1'b0;
      base_vid_i    = AW'(10'h155);
      if (n == 1) begin
        chk("busy_running", 64'(busy_o), 64'd1);
        var_states_i = ~var_states_i;
      end
      if (n == pulse_at) start_store_i = 1'b1;
      if (n == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_rd_en", 64'(mif.mem_rd_en), 64'd0);
        chk("rst_strobe", 64'(wr_states_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_max", 64'(load_max_lvl_o), 64'd0);
        exp_rd_q.delete();
        exp_stb_q.delete();
        exp_wr_q.delete();
        return;
      end
      if (done_o === 1'b1) begin
        seen = 1'b1;
        busy_at_done = busy_o;
      end
    end
    chk("latency", 64'(n), 64'(v.exp_lat));
    if (seen) chk("busy_at_done", 64'(busy_at_done), 64'd0);
    chk("load_max", 64'(load_max_lvl_o), 64'(v.exp_max));
    repeat (3) @(negedge clk);
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("leftover", 64'(exp_rd_q.size() + exp_stb_q.size() + exp_wr_q.size()), 64'd0);
  endtask

  initial begin
    for (int k = 0; k < NV; k++) begin
      vecs[0].words[k] = {3'b010, WL'(k + 1)};
      vecs[2].words[k] = {3'b101, WL'(k)};
      vecs[3].words[k] = {3'b011, WL'(10 * k)};
      vecs[4].words[k] = {3'b111, WL'(16'hA000 + k)};
      vecs[5].words[k] = {3'b001, WL'(16'hFFFF)};
    end
    // var3 unassigned with a big level; var6 has value 3'b001, also unassigned.
    vecs[1].words[0] = {3'b010, 16'd1};
    vecs[1].words[1] = {3'b100, 16'd2};
    vecs[1].words[2] = {3'b110, 16'd5};
    vecs[1].words[3] = {3'b000, 16'd99};
    vecs[1].words[4] = {3'b011, 16'd3};
    vecs[1].words[5] = {3'b010, 16'd4};
    vecs[1].words[6] = {3'b001, 16'd50};
    vecs[1].words[7] = {3'b101, 16'd5};
    vecs[0].op = 0; vecs[0].base = 10'h010; vecs[0].exp_max = 16'd8;  vecs[0].exp_lat = 10;
    vecs[1].op = 0; vecs[1].base = 10'h100; vecs[1].exp_max = 16'd5;  vecs[1].exp_lat = 10;
    vecs[2].op = 1; vecs[2].base = 10'h200; vecs[2].exp_max = 16'd5;  vecs[2].exp_lat = 9;
    vecs[3].op = 2; vecs[3].base = 10'h3FE; vecs[3].exp_max = 16'd70; vecs[3].exp_lat = 10;
    vecs[4].op = 1; vecs[4].base = 10'h3FA; vecs[4].exp_max = 16'd70; vecs[4].exp_lat = 9;
    vecs[5].op = 0; vecs[5].base = 10'h3FC; vecs[5].exp_max = 16'd0;  vecs[5].exp_lat = 10;

    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_done", 64'(done_o), 64'd0);
    chk("reset_rd_en", 64'(mif.mem_rd_en), 64'd0);
    chk("reset_wr_en", 64'(mif.mem_wr_en), 64'd0);
    chk("reset_strobe", 64'(wr_states_o), 64'd0);
    chk("reset_addr", 64'({mif.mem_rd_addr, mif.mem_wr_addr}), 64'd0);
    chk("reset_max", 64'(load_max_lvl_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(i, 0, 0);
    run_vec(0, 3, 0);
    run_vec(1, 0, 4);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
